panel_writer: RTL and testbench
===============================

Name: panel_writer

Overview:
Front-panel input block that writes user-entered data into the register file or data memory. It is the write-side counterpart of the seven-segment readout path.
- A 32-bit word is staged in two 16-bit halves from slide switches using debounced push-buttons.
- A commit button issues a single-cycle write strobe to the register file or the memory, selected by a switch.
- The staged word is exported so the display path can show it.

Parameters:
DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles a synchronized button level must hold before the debounced level changes (10 ms at 100 MHz).
CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  synchronous active-high reset.
- ToMem  in  1  target select: 0 = register file, 1 = data memory.
- Addr  in  6  target address; the register file uses Addr[4:0].
- Sw  in  16  half-word entry switches.
- BtnLo  in  1  raw button: load Sw into Staged[15:0].
- BtnHi  in  1  raw button: load Sw into Staged[31:16].
- BtnWr  in  1  raw button: commit a write.
- WriteReg  out  5  register-file write address.
- WriteMem  out  6  memory write address.
- WriteData  out  32  write data.
- RegWe  out  1  register-file write enable, one-cycle pulse.
- MemWe  out  1  memory write enable, one-cycle pulse.
- Busy  out  1  high while a commit is in progress.
- Staged  out  32  currently staged word.

Behaviour:
Reset and clocking:
- clk is the only clock. clr is synchronous and active-high.
- While clr = 1: every output is 0, the FSM is in IDLE, all synchronizers, debounce counters, debounced levels and edge registers are 0.

Button conditioning (identical for BtnLo, BtnHi, BtnWr):
- Each raw button passes through a 2-flop synchronizer.
- Counter behaviour: when the synchronized level differs from the debounced level, the counter increments; otherwise the counter clears.
- When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the debounced level flips and the counter clears.
- A registered rising edge of the debounced level produces a one-cycle pulse: loP, hiP, wrP.
- Falling edges produce no pulse.
- Bounces shorter than DEBOUNCE_CYCLES produce no pulse.

FSM states:
- IDLE
  - loP: Staged[15:0] <= Sw.
  - hiP: Staged[31:16] <= Sw.
  - loP and hiP in the same cycle: both halves load from the same Sw value.
  - wrP: WriteReg <= Addr[4:0] when ToMem = 0, else unchanged; WriteMem <= Addr when ToMem = 1, else unchanged. WriteData <= Staged, using the value before any same-cycle loP/hiP update. Latch the target select; go to WRITE.
  - wrP together with loP/hiP: the load still updates Staged, but the write uses the old word.
- WRITE
  - RegWe = 1 if the latched select is 0, else MemWe = 1. Never both.
  - Exactly one cycle in this state; then go to HOLD.
- HOLD
  - Stay until the debounced BtnWr level is 0, then go to IDLE.
  - This gives exactly one write per press.

Outputs and boundary conditions:
- Busy = 1 in WRITE and HOLD.
- loP and hiP are ignored while Busy; Staged is unchanged.
- Staged persists after a write and is only changed by loP/hiP or reset.
- Latency: the wrP pulse at cycle N gives a write-enable high in cycle N+1 only. RegWe and MemWe are registered.
- WriteReg, WriteMem and WriteData hold their values after the write until the next commit.
- A write to register 0 is still issued; the register file ignores it.
- ToMem and Addr changes after wrP do not affect the in-flight write.
- clr asserted during WRITE: the strobe drops in the following cycle, no further write occurs, and the FSM returns to IDLE.
- Button held across reset: after clr deasserts it must be re-debounced before a pulse is produced.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4.
1. Sw = 16'h1234, press BtnLo; Sw = 16'hABCD, press BtnHi -> Staged = 32'hABCD1234; RegWe = MemWe = 0 throughout.
2. Staged = 32'hABCD1234, ToMem = 0, Addr = 6'd5, press BtnWr and hold 50 cycles -> RegWe high for exactly 1 cycle with WriteReg = 5 and WriteData = 32'hABCD1234; MemWe stays 0; Busy falls after release is debounced.
3. ToMem = 1, Addr = 6'd63, Staged = 32'hDEADBEEF, press BtnWr -> MemWe pulses once with WriteMem = 63 and WriteData = 32'hDEADBEEF; RegWe stays 0.
4. Toggle BtnLo with 1-3-cycle glitches, then hold it low -> no loP pulse and Staged unchanged; a clean 10-cycle press -> a single load.
5. Press BtnHi with Sw = 16'h0F0F while Busy (in HOLD) -> Staged[31:16] unchanged; repeat after return to IDLE -> Staged[31:16] = 16'h0F0F.
6. Assert clr in the WRITE cycle -> the following cycle shows all outputs 0 and no enable pulse; a second BtnWr press after reset writes Staged = 0.

Source files
------------

// File: rtl/panel_writer.sv
// panel_writer: front-panel write path into the register file or data memory.
//
// Three raw push-buttons are each synchronized (2 flops), debounced, and
// turned into one-cycle rising-edge pulses. BtnLo/BtnHi load the slide
// switches into the low/high half of the staged word. BtnWr commits the staged
// word as a single-cycle write to the register file (ToMem = 0) or to the data
// memory (ToMem = 1).
//
// Ports:
//   clk        system clock, rising edge
//   clr        synchronous active-high reset
//   ToMem      target select: 0 = register file, 1 = data memory
//   Addr[5:0]  target address (register file uses Addr[4:0])
//   Sw[15:0]   half-word entry switches
//   BtnLo      raw button, load Sw into Staged[15:0]
//   BtnHi      raw button, load Sw into Staged[31:16]
//   BtnWr      raw button, commit a write
//   WriteReg   register-file write address
//   WriteMem   memory write address
//   WriteData  write data
//   RegWe      register-file write enable (one-cycle pulse)
//   MemWe      memory write enable (one-cycle pulse)
//   Busy       high while a commit is in progress
//   Staged     currently staged word
module panel_writer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        ToMem,
  input  logic [5:0]  Addr,
  input  logic [15:0] Sw,
  input  logic        BtnLo,
  input  logic        BtnHi,
  input  logic        BtnWr,
  output logic [4:0]  WriteReg,
  output logic [5:0]  WriteMem,
  output logic [31:0] WriteData,
  output logic        RegWe,
  output logic        MemWe,
  output logic        Busy,
  output logic [31:0] Staged
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Button bit order: 0 = Lo, 1 = Hi, 2 = Wr.
  logic [2:0]       raw;
  logic [2:0]       sync_p0;
  logic [2:0]       sync_p1;
  logic [2:0]       db;
  logic [2:0]       db_d;
  logic [2:0]       pulse;
  logic [CNT_W-1:0] cnt [3];

  state_t state;
  state_t state_nxt;

  assign raw = {BtnWr, BtnHi, BtnLo};

  // Stage p0/p1: two-flop synchronizer, then per-button debounce counter.
  // The counter only runs while the synchronized level disagrees with the
  // debounced level, so any agreeing sample restarts the qualification window.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      db      <= '0;
      db_d    <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      db_d    <= db;
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] != db[i]) begin
          if (cnt[i] == CNT_LAST) begin
            db[i]  <= sync_p1[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Rising edges of the registered debounced levels only.
  assign pulse = db & ~db_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // HOLD waits for the debounced release so one press yields one write.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pulse[2]) state_nxt = WRITE;
      WRITE:   state_nxt = HOLD;
      HOLD:    if (!db[2]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);

  // Stage p2: staging and commit registers. The write enables are registered
  // on entry to WRITE, so they are high exactly for the WRITE cycle and carry
  // the target select captured at the commit pulse. WriteData takes the
  // pre-update Staged value when a load pulse coincides with the commit.
  always_ff @(posedge clk) begin
    if (clr) begin
      Staged    <= '0;
      WriteData <= '0;
      WriteReg  <= '0;
      WriteMem  <= '0;
      RegWe     <= 1'b0;
      MemWe     <= 1'b0;
    end else begin
      RegWe <= 1'b0;
      MemWe <= 1'b0;
      if (state == IDLE) begin
        if (pulse[0]) Staged[15:0]  <= Sw;
        if (pulse[1]) Staged[31:16] <= Sw;
        if (pulse[2]) begin
          WriteData <= Staged;
          if (ToMem) begin
            WriteMem <= Addr;
            MemWe    <= 1'b1;
          end else begin
            WriteReg <= Addr[4:0];
            RegWe    <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_panel_writer.sv
// Testbench for panel_writer with DEBOUNCE_CYCLES = 4.
// A behavioural model (delay lines, sample windows, a three-phase commit
// process) runs alongside the DUT and is compared every cycle; directed table
// vectors and hand-written sequences cover the commit and reset corner cases.
module tb_panel_writer;

  localparam int D = 4;

  logic        clk;
  logic        clr;
  logic        ToMem;
  logic [5:0]  Addr;
  logic [15:0] Sw;
  logic        BtnLo;
  logic        BtnHi;
  logic        BtnWr;
  logic [4:0]  WriteReg;
  logic [5:0]  WriteMem;
  logic [31:0] WriteData;
  logic        RegWe;
  logic        MemWe;
  logic        Busy;
  logic [31:0] Staged;

  panel_writer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .clr(clr),
    .ToMem(ToMem),
    .Addr(Addr),
    .Sw(Sw),
    .BtnLo(BtnLo),
    .BtnHi(BtnHi),
    .BtnWr(BtnWr),
    .WriteReg(WriteReg),
    .WriteMem(WriteMem),
    .WriteData(WriteData),
    .RegWe(RegWe),
    .MemWe(MemWe),
    .Busy(Busy),
    .Staged(Staged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a raw level reaches the debouncer two cycles late; the
  // debounced level flips once the last D delivered samples all disagree with it.
  logic [1:0]   m_pipe [3];
  logic [D-1:0] m_hist [3];
  int           m_fill [3];
  logic         m_db   [3];
  logic         m_dbd  [3];
  int           m_mode;          // 0 idle, 1 write cycle, 2 wait for release
  logic [31:0]  m_staged;
  logic [31:0]  m_wdata;
  logic [4:0]   m_wreg;
  logic [5:0]   m_wmem;
  logic         m_regwe;
  logic         m_memwe;

  always @(posedge clk) begin
    logic lo_p, hi_p, wr_p, rb;
    if (clr) begin
      for (int b = 0; b < 3; b++) begin
        m_pipe[b] = '0;
        m_hist[b] = '0;
        m_fill[b] = 0;
        m_db[b]   = 1'b0;
        m_dbd[b]  = 1'b0;
      end
      m_mode   = 0;
      m_staged = '0;
      m_wdata  = '0;
      m_wreg   = '0;
      m_wmem   = '0;
      m_regwe  = 1'b0;
      m_memwe  = 1'b0;
    end else begin
      lo_p = m_db[0] && !m_dbd[0];
      hi_p = m_db[1] && !m_dbd[1];
      wr_p = m_db[2] && !m_dbd[2];
      m_regwe = 1'b0;
      m_memwe = 1'b0;
      if (m_mode == 0) begin
        if (wr_p) begin
          m_wdata = m_staged;
          if (ToMem) begin
            m_wmem  = Addr;
            m_memwe = 1'b1;
          end else begin
            m_wreg  = Addr[4:0];
            m_regwe = 1'b1;
          end
          m_mode = 1;
        end
        if (lo_p) m_staged[15:0]  = Sw;
        if (hi_p) m_staged[31:16] = Sw;
      end else if (m_mode == 1) begin
        m_mode = 2;
      end else begin
        if (!m_db[2]) m_mode = 0;
      end
      for (int b = 0; b < 3; b++) begin
        rb = (b == 0) ? BtnLo : (b == 1) ? BtnHi : BtnWr;
        m_dbd[b]  = m_db[b];
        m_hist[b] = {m_hist[b][D-2:0], m_pipe[b][1]};
        if (m_fill[b] < D) m_fill[b]++;
        if (m_fill[b] >= D && m_hist[b] == {D{~m_db[b]}}) m_db[b] = ~m_db[b];
        m_pipe[b] = {m_pipe[b][0], rb};
      end
    end
  end

  int checks;
  int failures;
  int nprint;
  int reg_cnt;
  int mem_cnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Advance n cycles; each cycle is sampled 2 ns after the edge and compared
  // with the model.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      checks++;
      if ({RegWe, MemWe, Busy, Staged, WriteReg, WriteMem, WriteData} !==
          {m_regwe, m_memwe, (m_mode != 0), m_staged, m_wreg, m_wmem, m_wdata}) begin
        failures++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL model t=%0t got we=%b%b busy=%b st=%h wr=%0d wm=%0d wd=%h expected we=%b%b busy=%b st=%h wr=%0d wm=%0d wd=%h",
                   $time, RegWe, MemWe, Busy, Staged, WriteReg, WriteMem, WriteData,
                   m_regwe, m_memwe, (m_mode != 0), m_staged, m_wreg, m_wmem, m_wdata);
        end
      end
      reg_cnt += int'(RegWe);
      mem_cnt += int'(MemWe);
    end
  endtask

  // btn: 0 Lo, 1 Hi, 2 Wr, 3 Lo and Hi together
  task automatic set_btn(input int b, input logic v);
    case (b)
      0: BtnLo = v;
      1: BtnHi = v;
      2: BtnWr = v;
      default: begin
        BtnLo = v;
        BtnHi = v;
      end
    endcase
  endtask

  typedef struct {
    int          btn;
    logic [15:0] sw;
    logic        tomem;
    logic [5:0]  addr;
    int          hold;
    logic [31:0] exp_staged;
    int          exp_reg;
    int          exp_mem;
    logic [5:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [8];
  int   glitch [6];
  int   run [3];
  logic lvl [3];

  initial begin
    checks   = 0;
    failures = 0;
    nprint   = 0;
    reg_cnt  = 0;
    mem_cnt  = 0;
    clr   = 1'b1;
    ToMem = 1'b0;
    Addr  = '0;
    Sw    = '0;
    BtnLo = 1'b0;
    BtnHi = 1'b0;
    BtnWr = 1'b0;

    tbl[0] = '{0, 16'h1234, 1'b0, 6'd0,  10, 32'h0000_1234, 0, 0, 6'd0,  32'h0};
    tbl[1] = '{1, 16'hABCD, 1'b0, 6'd0,  10, 32'hABCD_1234, 0, 0, 6'd0,  32'h0};
    tbl[2] = '{2, 16'h0000, 1'b0, 6'd5,  50, 32'hABCD_1234, 1, 0, 6'd5,  32'hABCD_1234};
    tbl[3] = '{0, 16'hBEEF, 1'b0, 6'd0,  10, 32'hABCD_BEEF, 0, 0, 6'd0,  32'h0};
    tbl[4] = '{1, 16'hDEAD, 1'b0, 6'd0,  10, 32'hDEAD_BEEF, 0, 0, 6'd0,  32'h0};
    tbl[5] = '{2, 16'h0000, 1'b1, 6'd63, 50, 32'hDEAD_BEEF, 0, 1, 6'd63, 32'hDEAD_BEEF};
    tbl[6] = '{2, 16'h0000, 1'b0, 6'h20, 30, 32'hDEAD_BEEF, 1, 0, 6'd0,  32'hDEAD_BEEF};
    tbl[7] = '{3, 16'h5A5A, 1'b0, 6'd0,  10, 32'h5A5A_5A5A, 0, 0, 6'd0,  32'h0};

    glitch[0] = 1; glitch[1] = 2; glitch[2] = 3;
    glitch[3] = 2; glitch[4] = 1; glitch[5] = 3;

    // Reset state
    cyc(3);
    check("rst_staged", Staged, 32'h0);
    check("rst_wdata", WriteData, 32'h0);
    check("rst_we_busy", {29'h0, RegWe, MemWe, Busy}, 32'h0);
    check("rst_addr", {21'h0, WriteReg, WriteMem}, 32'h0);
    clr = 1'b0;
    cyc(2);

    // Table-driven presses
    for (int i = 0; i < 8; i++) begin
      Sw    = tbl[i].sw;
      ToMem = tbl[i].tomem;
      Addr  = tbl[i].addr;
      reg_cnt = 0;
      mem_cnt = 0;
      set_btn(tbl[i].btn, 1'b1);
      for (int k = 0; k < tbl[i].hold; k++) begin
        cyc(1);
        if (k == 20) begin
          // In-flight commit must not see late select/address changes
          ToMem = ~ToMem;
          Addr  = ~Addr;
        end
        if (k == 25 && tbl[i].btn == 2) check($sformatf("v%0d_busy_held", i), {31'h0, Busy}, 32'h1);
      end
      set_btn(tbl[i].btn, 1'b0);
      cyc(15);
      check($sformatf("v%0d_staged", i), Staged, tbl[i].exp_staged);
      check($sformatf("v%0d_regwe_cycles", i), reg_cnt, tbl[i].exp_reg);
      check($sformatf("v%0d_memwe_cycles", i), mem_cnt, tbl[i].exp_mem);
      check($sformatf("v%0d_busy_idle", i), {31'h0, Busy}, 32'h0);
      if (tbl[i].exp_reg + tbl[i].exp_mem > 0) begin
        check($sformatf("v%0d_wdata", i), WriteData, tbl[i].exp_data);
        if (tbl[i].tomem)
          check($sformatf("v%0d_wmem", i), {26'h0, WriteMem}, {26'h0, tbl[i].exp_addr});
        else
          check($sformatf("v%0d_wreg", i), {26'h0, WriteReg}, {26'h0, tbl[i].exp_addr});
      end
    end

    // Short glitches on BtnLo must not load
    Sw = 16'h7777;
    for (int g = 0; g < 6; g++) begin
      BtnLo = 1'b1;
      cyc(glitch[g]);
      BtnLo = 1'b0;
      cyc(1);
    end
    cyc(10);
    check("glitch_no_load", Staged, 32'h5A5A_5A5A);
    BtnLo = 1'b1;
    cyc(10);
    BtnLo = 1'b0;
    cyc(10);
    check("clean_lo_load", Staged, 32'h5A5A_7777);

    // BtnHi while Busy is ignored; after release it loads
    ToMem = 1'b0;
    Addr  = 6'd7;
    reg_cnt = 0;
    BtnWr = 1'b1;
    cyc(20);
    check("hold_busy", {31'h0, Busy}, 32'h1);
    Sw = 16'h0F0F;
    BtnHi = 1'b1;
    cyc(10);
    BtnHi = 1'b0;
    cyc(10);
    check("hi_ignored_busy", Staged, 32'h5A5A_7777);
    BtnWr = 1'b0;
    cyc(15);
    check("hold_released", {31'h0, Busy}, 32'h0);
    check("hold_one_write", reg_cnt, 1);
    BtnHi = 1'b1;
    cyc(10);
    BtnHi = 1'b0;
    cyc(10);
    check("hi_after_idle", Staged, 32'h0F0F_7777);

    // Reset during the WRITE cycle
    Addr = 6'd9;
    BtnWr = 1'b1;
    for (int k = 0; k < 40 && !RegWe; k++) cyc(1);
    check("wait_write_strobe", {31'h0, RegWe}, 32'h1);
    clr = 1'b1;
    BtnWr = 1'b0;
    cyc(1);
    check("clr_we_busy", {29'h0, RegWe, MemWe, Busy}, 32'h0);
    check("clr_staged", Staged, 32'h0);
    check("clr_wdata", WriteData, 32'h0);
    check("clr_addr", {21'h0, WriteReg, WriteMem}, 32'h0);
    reg_cnt = 0;
    mem_cnt = 0;
    cyc(3);
    clr = 1'b0;
    cyc(10);
    check("clr_no_more_write", reg_cnt + mem_cnt, 0);
    BtnWr = 1'b1;
    cyc(12);
    BtnWr = 1'b0;
    cyc(15);
    check("post_clr_write_cnt", reg_cnt, 1);
    check("post_clr_wdata", WriteData, 32'h0);
    check("post_clr_wreg", {27'h0, WriteReg}, 32'd9);

    // Randomized activity against the model, including resets mid-press
    for (int b = 0; b < 3; b++) begin
      run[b] = 0;
      lvl[b] = 1'b0;
    end
    for (int k = 0; k < 4000; k++) begin
      for (int b = 0; b < 3; b++) begin
        if (run[b] == 0) begin
          lvl[b] = ~lvl[b];
          run[b] = $urandom_range(1, 12);
        end
        run[b]--;
      end
      BtnLo = lvl[0];
      BtnHi = lvl[1];
      BtnWr = lvl[2];
      Sw    = 16'($urandom);
      Addr  = 6'($urandom);
      ToMem = 1'($urandom);
      clr   = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    clr = 1'b0;
    cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
